// File: rtl/counter6_step_ctrl_if.sv
// Button/step bundle between the board push-buttons and the mod-6 counter's enable/direction inputs.
// The master drives the raw buttons; the slave returns registered step/dir/held. No backpressure.
interface counter6_step_ctrl_if;
  logic btn_up;
  logic btn_down;
  logic step;
  logic dir;
  logic held;

  modport master (output btn_up, btn_down, input step, dir, held);
  modport slave  (input btn_up, btn_down, output step, dir, held);
endinterface

// File: rtl/counter6_step_ctrl.sv
// Debounced up/down step generator with hold-to-repeat; first step DEBOUNCE_CYCLES+3 edges after a press.
// All outputs registered; no backpressure, the counter must accept every step pulse.
module counter6_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 10,
  parameter int REPEAT_PERIOD   = 3,
  parameter int CNT_W           = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  counter6_step_ctrl_if.slave   io_bus
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT, S_LOCKOUT} state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_DLY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_PER = CNT_W'(REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Bit 1 carries the up button, bit 0 the down button.
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       w_deb;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_rpt;
  logic [CNT_W-1:0] w_rpt_nxt;
  logic             r_step;
  logic             r_dir;
  logic             r_held;
  logic             w_step_nxt;
  logic             w_dir_nxt;
  logic             w_held_nxt;
  logic             w_up;
  logic             w_dn;
  logic             w_act;
  logic             w_oth;
  logic             w_rpt_due;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= {io_bus.btn_up, io_bus.btn_down};
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_db
    logic [CNT_W-1:0] r_cnt;
    logic             r_lvl;

    // The flip happens on the edge that would bring the mismatch run to DEBOUNCE_CYCLES.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else if (r_sync2[g] == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        r_cnt <= '0;
        r_lvl <= ~r_lvl;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end

    assign w_deb[g] = r_lvl;
  end

  assign w_up = w_deb[1];
  assign w_dn = w_deb[0];
  // r_dir always names the button that started the current press.
  assign w_act     = r_dir ? w_up : w_dn;
  assign w_oth     = r_dir ? w_dn : w_up;
  assign w_rpt_due = (r_state == S_DELAY) ? (r_rpt == RPT_DLY) : (r_rpt == RPT_PER);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_rpt   <= '0;
      r_step  <= 1'b0;
      r_dir   <= 1'b1;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rpt   <= w_rpt_nxt;
      r_step  <= w_step_nxt;
      r_dir   <= w_dir_nxt;
      r_held  <= w_held_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_up && w_dn)      w_state_nxt = S_LOCKOUT;
        else if (w_up || w_dn) w_state_nxt = S_DELAY;
      end
      S_DELAY, S_REPEAT: begin
        if (!w_act)         w_state_nxt = S_IDLE;
        else if (w_oth)     w_state_nxt = S_LOCKOUT;
        else if (w_rpt_due) w_state_nxt = S_REPEAT;
      end
      S_LOCKOUT: begin
        if (!w_up && !w_dn) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_step_nxt = 1'b0;
    w_dir_nxt  = r_dir;
    w_rpt_nxt  = r_rpt;
    unique case (r_state)
      S_IDLE: begin
        if (w_up ^ w_dn) begin
          w_step_nxt = 1'b1;
          w_dir_nxt  = w_up;
          w_rpt_nxt  = CNT_ONE;
        end
      end
      S_DELAY, S_REPEAT: begin
        if (w_act && !w_oth) begin
          if (w_rpt_due) begin
            w_step_nxt = 1'b1;
            w_rpt_nxt  = CNT_ONE;
          end else begin
            w_rpt_nxt  = r_rpt + CNT_ONE;
          end
        end
      end
      default: begin
      end
    endcase
    w_held_nxt = (w_state_nxt == S_REPEAT);
  end

  assign io_bus.step = r_step;
  assign io_bus.dir  = r_dir;
  assign io_bus.held = r_held;

endmodule

// File: tb/tb_counter6_step_ctrl.sv
// Directed bench for counter6_step_ctrl: per-cycle comparison against a press-age model,
// plus literal step-edge expectations for each scenario.
module tb_counter6_step_ctrl;
  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  counter6_step_ctrl_if bus ();

  counter6_step_ctrl #(
    .DEBOUNCE_CYCLES (DC),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .CNT_W           (16)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  initial forever #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  // Model: debounced level flips once the last DC synchronized samples all disagree with it;
  // a press is tracked by its age in cycles since the first step.
  bit             m_valid = 1'b0;
  logic [DC+1:0]  hu = '0;
  logic [DC+1:0]  hd = '0;
  bit             m_du, m_dd;
  int             m_mode;   // 0 idle, 1 pressed, 2 locked out
  bit             m_a;
  int             m_age;
  bit             m_step, m_dir, m_held;

  function automatic bit settle(bit cur, logic [DC+1:0] h);
    bit all_diff = 1'b1;
    for (int k = 0; k < DC; k++)
      if (h[k+1] == cur) all_diff = 1'b0;
    return all_diff ? !cur : cur;
  endfunction

  task automatic model_edge(bit rst_ok, bit ru, bit rdn);
    bit act, oth;
    if (!rst_ok) begin
      m_valid = 1'b1;
      hu = '0; hd = '0;
      m_du = 1'b0; m_dd = 1'b0;
      m_mode = 0; m_age = 0; m_a = 1'b1;
      m_step = 1'b0; m_dir = 1'b1; m_held = 1'b0;
      return;
    end
    m_step = 1'b0;
    case (m_mode)
      0: begin
        if (m_du && m_dd) m_mode = 2;
        else if (m_du || m_dd) begin
          m_mode = 1; m_a = m_du; m_age = 0; m_step = 1'b1; m_dir = m_du;
        end
      end
      1: begin
        act = m_a ? m_du : m_dd;
        oth = m_a ? m_dd : m_du;
        if (!act) m_mode = 0;
        else if (oth) m_mode = 2;
        else begin
          m_age++;
          if (m_age >= RD && (m_age - RD) % RP == 0) m_step = 1'b1;
        end
      end
      default: if (!m_du && !m_dd) m_mode = 0;
    endcase
    m_held = (m_mode == 1) && (m_age >= RD);
    m_du = settle(m_du, hu);
    m_dd = settle(m_dd, hd);
    hu = {hu[DC:0], ru};
    hd = {hd[DC:0], rdn};
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_edge(rst_n, bus.btn_up, bus.btn_down);
  end

  int log_cyc[$];
  int log_dir[$];
  int held_rise = -1;
  bit held_prev = 1'b0;

  function automatic int q_at(int i);
    if (i < log_cyc.size()) return log_cyc[i];
    return -1000;
  endfunction

  function automatic int dir_at(int i);
    if (i < log_dir.size()) return log_dir[i];
    return -1;
  endfunction

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("step", int'(bus.step), int'(m_step));
      chk("dir",  int'(bus.dir),  int'(m_dir));
      chk("held", int'(bus.held), int'(m_held));
      if (bus.step === 1'b1) begin
        log_cyc.push_back(cyc);
        log_dir.push_back(int'(bus.dir));
      end
      if (bus.held === 1'b1 && !held_prev) held_rise = cyc;
      held_prev = (bus.held === 1'b1);
    end
  end

  task automatic log_clear();
    log_cyc.delete();
    log_dir.delete();
    held_rise = -1;
  endtask

  int e0, f0, d0;

  initial begin
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_step", int'(bus.step), 0);
    chk("rst_dir",  int'(bus.dir),  1);
    chk("rst_held", int'(bus.held), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single press.
    log_clear();
    bus.btn_up = 1'b1; e0 = cyc + 1;
    repeat (8) @(negedge clk);
    bus.btn_up = 1'b0;
    repeat (20) @(negedge clk);
    chk("single_nsteps", log_cyc.size(), 1);
    chk("single_lat", q_at(0) - e0, 6);
    chk("single_dir", dir_at(0), 1);
    chk("single_held", held_rise, -1);

    // Bounce on down, final rising sample at f0.
    log_clear();
    e0 = cyc + 1;
    for (int i = 0; i < 5; i++) begin
      bus.btn_down = (i % 2 == 0);
      @(negedge clk);
    end
    f0 = e0 + 4;
    repeat (7) @(negedge clk);
    bus.btn_down = 1'b0;
    repeat (20) @(negedge clk);
    chk("bounce_nsteps", log_cyc.size(), 1);
    chk("bounce_lat", q_at(0) - f0, 6);
    chk("bounce_dir", dir_at(0), 0);

    // Auto-repeat, 40 cycles held.
    log_clear();
    bus.btn_up = 1'b1; e0 = cyc + 1;
    repeat (40) @(negedge clk);
    bus.btn_up = 1'b0;
    repeat (20) @(negedge clk);
    chk("rpt_nsteps", log_cyc.size(), 11);
    chk("rpt_s0", q_at(0) - e0, 6);
    chk("rpt_s1", q_at(1) - e0, 16);
    chk("rpt_s2", q_at(2) - e0, 19);
    chk("rpt_last", q_at(10) - e0, 43);
    chk("rpt_dir", dir_at(10), 1);
    chk("rpt_held_rise", held_rise - e0, 16);

    // Conflict: down raised while up is repeating.
    log_clear();
    bus.btn_up = 1'b1; e0 = cyc + 1;
    repeat (20) @(negedge clk);
    bus.btn_down = 1'b1;
    repeat (20) @(negedge clk);
    chk("conf_held_lock", int'(bus.held), 0);
    bus.btn_up = 1'b0;
    repeat (15) @(negedge clk);
    chk("conf_nsteps_lock", log_cyc.size(), 5);
    bus.btn_down = 1'b0;
    repeat (15) @(negedge clk);
    bus.btn_down = 1'b1; d0 = cyc + 1;
    repeat (8) @(negedge clk);
    bus.btn_down = 1'b0;
    repeat (20) @(negedge clk);
    chk("conf_last_up", q_at(4) - e0, 25);
    chk("conf_nsteps", log_cyc.size(), 6);
    chk("conf_down_lat", q_at(5) - d0, 6);
    chk("conf_down_dir", dir_at(5), 0);

    // Reset while up is held; reset sampled on e0+20 and e0+21.
    log_clear();
    bus.btn_up = 1'b1; e0 = cyc + 1;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstmid_step", int'(bus.step), 0);
    chk("rstmid_held", int'(bus.held), 0);
    chk("rstmid_dir", int'(bus.dir), 1);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    bus.btn_up = 1'b0;
    repeat (20) @(negedge clk);
    chk("rstmid_nsteps", log_cyc.size(), 4);
    chk("rstmid_pre", q_at(2) - e0, 19);
    chk("rstmid_fresh", q_at(3) - e0, 28);

    // Simultaneous press.
    log_clear();
    bus.btn_up = 1'b1; bus.btn_down = 1'b1;
    repeat (20) @(negedge clk);
    bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    repeat (15) @(negedge clk);
    chk("simul_nsteps", log_cyc.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/counter6_step_ctrl.md
# counter6_step_ctrl

Step controller for the mod-6 up/down display counter. Turns two raw, bouncing push-buttons (up, down) into clean single-cycle step commands with a direction bit, including hold-to-auto-repeat. It sits between the board buttons and the counter's clock-enable/direction inputs, so the counter advances exactly once per intentional press or repeat tick.

## Interface
- DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples (≥1) required before a debounced level changes.
- REPEAT_DELAY, default 10: cycles (≥2) from the first step to the first auto-repeat step while held.
- REPEAT_PERIOD, default 3: cycles (≥2) between subsequent auto-repeat steps.
- CNT_W, default 16: width of internal counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).
- Clock and reset: one clock; reset is synchronous and active-low.
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- btn_up  input  1  raw up button, asynchronous, 1 = pressed.
- btn_down  input  1  raw down button, asynchronous, 1 = pressed.
- step  output  1  one-cycle pulse; counter advances once per pulse.
- dir  output  1  1 = increment, 0 = decrement; valid when step=1, holds its last value otherwise.
- held  output  1  1 while auto-repeat is active (REPEAT state).

## Operation
- Synchronizer: each button passes through a 2-flop synchronizer (sync1, sync2).
- Debounce, per button:
  - The counter clears whenever sync2 equals the debounced level.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- FSM states: IDLE, DELAY, REPEAT, LOCKOUT. Rpt counter width is CNT_W.
  - IDLE, exactly one debounced button high: pulse step; set dir (up=1, down=0); load rpt=1; go to DELAY.
  - IDLE, both debounced buttons rise in the same cycle: no step; go to LOCKOUT.
  - DELAY: rpt increments each cycle.
    - Active button released: go to IDLE, no step.
    - Other button goes high: go to LOCKOUT, no step.
    - rpt reaches REPEAT_DELAY: pulse step (same dir); rpt=1; go to REPEAT.
  - REPEAT: held=1; same release and other-button rules as DELAY.
    - rpt reaches REPEAT_PERIOD: pulse step; rpt=1.
  - LOCKOUT: no steps; return to IDLE only when both debounced levels are 0.
- Release and conflict checks take priority over a step due in the same cycle.
- step is never high in two consecutive cycles.
- Reset values: step=0, dir=1, held=0, sync flops=0, debounced levels=0, all counters=0, state=IDLE.
- Reset asserted mid-press: all state clears. If the button is still held after reset deasserts, it re-debounces and produces a fresh first step after the normal latency.

## Timing
- Let E0 be the first clock edge sampling the raw button high, with the raw level stable from then on.
- sync2=1 after E1; debounced=1 after E(1+DEBOUNCE_CYCLES); step high for the one cycle after E(2+DEBOUNCE_CYCLES).
- Let S0 be the edge producing the first step. Repeat steps follow at S0+REPEAT_DELAY, then every REPEAT_PERIOD cycles.
- held rises on edge S0+REPEAT_DELAY and falls on the edge that leaves REPEAT.
- Release latency: a raw release at E0 becomes debounced 0 after E(1+DEBOUNCE_CYCLES). The FSM leaves DELAY/REPEAT on the next edge.
- A raw pulse or bounce shorter than DEBOUNCE_CYCLES synchronized cycles never changes the debounced level.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All cases use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.

- Single press: btn_up high from E0 for 8 cycles, then low → exactly one step with dir=1, during the cycle after E6; held stays 0.
- Bounce rejection: btn_down toggles 1,0,1,0,1 over 5 cycles, then stays 1 → no step during the bounce; one step with dir=0 exactly 6 edges after the final rising sample; the glitch pulses alone produce nothing.
- Auto-repeat: btn_up held 40 cycles → steps at E6, E16, E19, E22, …; held=1 from E16; no step after the debounced release.
- Conflict: hold btn_up into REPEAT, then raise btn_down → steps stop within 7 cycles and held=0. Release btn_down only → still no steps. Release both, then press btn_down → one step with dir=0.
- Reset mid-hold: btn_up held; reset=0 for 2 cycles at cycle 20, button still held → step/held=0 during reset; new first step 7 edges after reset deasserts (synchronizer refill plus debounce).
- Simultaneous press: both buttons rise on the same edge → zero steps until both are released.
